// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: two-player tank game flow sequencer (idle, play, respawn freeze, final countdown, game over)
// Ports: frame_clk/Reset (async, active-high); start_btn level; p1_hit/p2_hit one-frame pulses;
// endgame from the final countdown timer; startfinaltimer runs that timer; game_state, p1_lives,
// p2_lives, winner (01 P1, 10 P2, 11 draw) and freeze are all registered.
module game_flow_ctrl #(
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 90
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start_btn,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       endgame,
  output logic       startfinaltimer,
  output logic [2:0] game_state,
  output logic [1:0] p1_lives,
  output logic [1:0] p2_lives,
  output logic [1:0] winner,
  output logic       freeze
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, RESPAWN = 3'd2, FINAL = 3'd3, OVER = 3'd4} state_t;
  localparam logic [1:0] L   = 2'(LIVES);
  localparam logic [7:0] RF1 = 8'(RESPAWN_FRAMES - 1);
  state_t     state, state_n;
  logic       prev, press;
  logic [7:0] cnt, cnt_n;
  logic [1:0] l1_n, l2_n, win_n, d1, d2;
  assign game_state = state;
  assign press      = start_btn & ~prev;
  assign d1         = (p1_hit && p1_lives != 2'd0) ? p1_lives - 2'd1 : p1_lives;
  assign d2         = (p2_hit && p2_lives != 2'd0) ? p2_lives - 2'd1 : p2_lives;
  always_comb begin
    state_n = IDLE;
    cnt_n   = cnt;
    l1_n    = p1_lives;
    l2_n    = p2_lives;
    win_n   = winner;
    case (state)
      IDLE:    state_n = press ? PLAY : IDLE;
      PLAY: begin
        state_n = PLAY;
        if (p1_hit | p2_hit) begin
          l1_n = d1;
          l2_n = d2;
          if (d1 == 2'd0 || d2 == 2'd0) begin
            state_n = FINAL;
            win_n   = {d1 == 2'd0, d2 == 2'd0};
          end else begin
            state_n = RESPAWN;
            cnt_n   = 8'd0;
          end
        end
      end
      RESPAWN: begin
        state_n = (cnt == RF1) ? PLAY : RESPAWN;
        cnt_n   = cnt + 8'd1;
      end
      FINAL:   state_n = endgame ? OVER : FINAL;
      OVER:    state_n = press ? IDLE : OVER;
      default: state_n = IDLE;
    endcase
    // Lives and result are reloaded on every edge that lands in IDLE, so OVER->IDLE already shows full lives.
    if (state_n == IDLE) begin
      l1_n  = L;
      l2_n  = L;
      win_n = 2'b00;
    end
  end
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      prev            <= 1'b1;
      cnt             <= 8'd0;
      p1_lives        <= L;
      p2_lives        <= L;
      winner          <= 2'b00;
      freeze          <= 1'b1;
      startfinaltimer <= 1'b0;
    end else begin
      state           <= state_n;
      prev            <= start_btn;
      cnt             <= cnt_n;
      p1_lives        <= l1_n;
      p2_lives        <= l2_n;
      winner          <= win_n;
      freeze          <= state_n != PLAY;
      startfinaltimer <= state_n == FINAL;
    end
  end
endmodule
